gcd_wb_array: RTL and testbench

Wishbone-slave accelerator holding NUM_CH independent iterative GCD engines of WIDTH-bit operands. It replaces the single fixed GCD unit inside user_proj_example. Each channel has memory-mapped operand, control/status and result registers. A level interrupt is raised on user_irq[0] when any enabled channel completes.

---
 rtl/gcd_wb_pkg.sv | 31 +++
 rtl/gcd_wb_array_if.sv | 21 ++
 rtl/gcd_engine.sv | 66 ++++++
 rtl/gcd_wb_array.sv | 120 ++++++++++++
 tb/tb_gcd_wb_array.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_wb_pkg.sv
// Shared definitions for the Wishbone GCD array: register offsets, CTRL bit
// positions, engine states and the byte-lane merge helper.
package gcd_wb_pkg;

  localparam logic [1:0] RegOpa    = 2'd0;
  localparam logic [1:0] RegOpb    = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegResult = 2'd3;

  // CTRL write bits
  localparam int unsigned CtrlStartBit   = 0;
  localparam int unsigned CtrlIrqEnBit   = 1;
  localparam int unsigned CtrlDoneClrBit = 2;
  // CTRL read bits
  localparam int unsigned CtrlBusyBit    = 0;
  localparam int unsigned CtrlDoneBit    = 2;

  typedef enum logic {StIdle, StCalc} eng_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gcd_wb_array_if.sv
// Wishbone slave bus bundle for the GCD array.
interface gcd_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/gcd_engine.sv
// Iterative subtract/swap GCD engine: one step per cycle while in StCalc.
module gcd_engine
  import gcd_wb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  eng_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_o   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = opa_i;
          b_d     = opb_i;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (b_q == '0) begin
          result_d = a_q;
          done_o   = 1'b1;
          state_d  = StIdle;
        end else if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          a_d = a_q - b_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == StCalc);
  assign result_o = result_q;

endmodule

// File: rtl/gcd_wb_array.sv
// Wishbone-mapped array of NUM_CH GCD engines with per-channel operand,
// control/status and result registers plus a level completion interrupt.
module gcd_wb_array
  import gcd_wb_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  gcd_wb_if.slave           wb,
  output logic [2:0]        user_irq,
  output logic [NUM_CH-1:0] busy_o
);

  localparam logic [32:0] AddrLo = {1'b0, BASE_ADDR};
  localparam logic [32:0] AddrHi = AddrLo + 33'(NUM_CH) * 33'd16;

  logic             ack_q, ack_d, irq_q, irq_d;
  logic [31:0]      dat_q, dat_d;
  logic [WIDTH-1:0] opa_q [NUM_CH];
  logic [WIDTH-1:0] opa_d [NUM_CH];
  logic [WIDTH-1:0] opb_q [NUM_CH];
  logic [WIDTH-1:0] opb_d [NUM_CH];
  logic [WIDTH-1:0] result [NUM_CH];
  logic [NUM_CH-1:0] irq_en_q, irq_en_d, done_q, done_d, start, eng_done;

  logic       in_range, hit, wr, rd;
  logic [2:0] ch_sel;
  logic [1:0] reg_sel;

  assign in_range = ({1'b0, wb.wbs_adr_i} >= AddrLo) && ({1'b0, wb.wbs_adr_i} < AddrHi);
  // No new hit while ack is up, so a held strobe acks every other cycle.
  assign hit      = wb.wbs_cyc_i && wb.wbs_stb_i && in_range && !ack_q;
  assign wr       = hit && wb.wbs_we_i;
  assign rd       = hit && !wb.wbs_we_i;
  assign ch_sel   = wb.wbs_adr_i[6:4] - BASE_ADDR[6:4];
  assign reg_sel  = wb.wbs_adr_i[3:2];

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    start    = '0;
    ack_d    = hit;
    dat_d    = '0;
    irq_d    = |(done_q & irq_en_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && ch_sel == 3'(i)) begin
        unique case (reg_sel)
          RegOpa: opa_d[i] = WIDTH'(merge_bytes(32'(opa_q[i]), wb.wbs_dat_i, wb.wbs_sel_i));
          RegOpb: opb_d[i] = WIDTH'(merge_bytes(32'(opb_q[i]), wb.wbs_dat_i, wb.wbs_sel_i));
          RegCtrl: begin
            if (wb.wbs_sel_i[0]) begin
              start[i]    = wb.wbs_dat_i[CtrlStartBit];
              irq_en_d[i] = wb.wbs_dat_i[CtrlIrqEnBit];
              if (wb.wbs_dat_i[CtrlDoneClrBit]) done_d[i] = 1'b0;
            end
          end
          default: ;
        endcase
      end
      // Priority: engine completion over accepted start over done_clr.
      if (start[i] && !busy_o[i]) done_d[i] = 1'b0;
      if (eng_done[i]) done_d[i] = 1'b1;
      if (rd && ch_sel == 3'(i)) begin
        unique case (reg_sel)
          RegOpa: dat_d = 32'(opa_q[i]);
          RegOpb: dat_d = 32'(opb_q[i]);
          RegCtrl: begin
            dat_d[CtrlBusyBit]  = busy_o[i];
            dat_d[CtrlIrqEnBit] = irq_en_q[i];
            dat_d[CtrlDoneBit]  = done_q[i];
          end
          default: dat_d = 32'(result[i]);
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      opa_q    <= '{default: '0};
      opb_q    <= '{default: '0};
      irq_en_q <= '0;
      done_q   <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_eng
    gcd_engine #(.WIDTH(WIDTH)) u_eng (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .start_i  (start[g]),
      .opa_i    (opa_q[g]),
      .opb_i    (opb_q[g]),
      .busy_o   (busy_o[g]),
      .done_o   (eng_done[g]),
      .result_o (result[g])
    );
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign user_irq     = {2'b00, irq_q};

endmodule

// File: tb/tb_gcd_wb_array.sv
// Directed plus randomized bench for gcd_wb_array against a Euclid reference.
module tb_gcd_wb_array;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] irq;
  logic [3:0] busy;

  gcd_wb_if bus ();

  gcd_wb_array #(.WIDTH(16), .NUM_CH(4), .BASE_ADDR(Base)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .user_irq (irq),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [31:0] addr(input int ch, input int r);
    return Base + 32'(ch * 16 + r * 4);
  endfunction

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  // One transfer; checks the ack arrives exactly one cycle after the strobe.
  task automatic wb_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rdata);
    int n;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = a;
    bus.wbs_dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wbs_ack_o && n < 4);
    rdata = bus.wbs_dat_o;
    bus_idle();
    check("ack_latency", 32'(n), 32'd1);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, addr(ch, r), d, 4'hF, dummy);
  endtask

  task automatic rd_check(input string tag, input int ch, input int r, input logic [31:0] exp);
    logic [31:0] v;
    wb_access(1'b0, addr(ch, r), 32'h0, 4'hF, v);
    check(tag, v, exp);
  endtask

  task automatic wait_idle(input int ch, input int max, output int n);
    n = 0;
    while (busy[ch] && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Strobe held for four cycles; returns the observed ack pattern (bit k = cycle k).
  task automatic held_access(input logic [31:0] a, output logic [3:0] pat);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = a;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      pat[k] = bus.wbs_ack_o;
    end
    bus_idle();
  endtask

  initial begin
    int          n;
    int          ch;
    logic [3:0]  pat;
    logic [31:0] ra, rb, v;

    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    for (int c = 0; c < 4; c++) begin
      rd_check("rst_ctrl", c, 2, 32'h0);
      rd_check("rst_result", c, 3, 32'h0);
    end
    held_access(addr(0, 2), pat);
    check("held_stb_pattern", 32'(pat), 32'h5);

    // Basic gcd(15,5): five steps
    wr(0, 0, 32'd15);
    wr(0, 1, 32'd5);
    wr(0, 2, 32'h1);
    check("basic_busy_start", 32'(busy[0]), 32'h1);
    wait_idle(0, 100, n);
    check("basic_cycles", 32'(n), 32'd5);
    rd_check("basic_result", 0, 3, 32'd5);
    rd_check("basic_ctrl", 0, 2, 32'h4);

    // Boundary operands on ch1
    wr(1, 0, 32'd0);
    wr(1, 1, 32'd0);
    wr(1, 2, 32'h1);
    wait_idle(1, 100, n);
    check("zz_cycles", 32'(n), 32'd1);
    rd_check("zz_result", 1, 3, 32'd0);
    wr(1, 1, 32'd9);
    wr(1, 2, 32'h1);
    wait_idle(1, 100, n);
    check("z9_cycles", 32'(n), 32'd2);
    rd_check("z9_result", 1, 3, 32'd9);
    wr(1, 0, 32'hFFFF);
    wr(1, 1, 32'hFFFE);
    wr(1, 2, 32'h1);
    wait_idle(1, 70000, n);
    check("max_done", 32'(busy[1]), 32'h0);
    rd_check("max_result", 1, 3, 32'd1);
    wr(1, 0, 32'h0001_2345);
    rd_check("opa_trunc", 1, 0, 32'h2345);
    wb_access(1'b1, addr(1, 0), 32'h0000_AB00, 4'b0010, v);
    rd_check("opa_bytelane", 1, 0, 32'hAB45);

    // Parallel channels, with an ignored restart on ch2
    wr(0, 0, 32'd48);  wr(0, 1, 32'd18);
    wr(1, 0, 32'd17);  wr(1, 1, 32'd5);
    wr(2, 0, 32'd100); wr(2, 1, 32'd75);
    wr(3, 0, 32'd7);   wr(3, 1, 32'd7);
    wr(2, 2, 32'h1);
    wr(2, 0, 32'd9);
    check("restart_busy", 32'(busy[2]), 32'h1);
    wr(2, 2, 32'h1);
    wr(0, 2, 32'h1);
    wr(1, 2, 32'h1);
    wr(3, 2, 32'h1);
    n = 0;
    while (busy != 4'h0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("par_all_done", 32'(busy), 32'h0);
    rd_check("par_r0", 0, 3, 32'd6);
    rd_check("par_r1", 1, 3, 32'd1);
    rd_check("par_r2", 2, 3, 32'd25);
    rd_check("par_r3", 3, 3, 32'd7);
    rd_check("par_ctrl2", 2, 2, 32'h4);

    // Interrupt: enabled on ch3 only
    do_reset(1);
    wr(3, 2, 32'h2);
    wr(0, 0, 32'd15);
    wr(0, 1, 32'd5);
    wr(0, 2, 32'h1);
    wait_idle(0, 100, n);
    repeat (2) @(posedge clk);
    #1 check("irq_ch0_none", 32'(irq), 32'h0);
    wr(3, 0, 32'd7);
    wr(3, 1, 32'd7);
    wr(3, 2, 32'h3);
    wait_idle(3, 100, n);
    check("irq_lag", 32'(irq[0]), 32'h0);
    @(posedge clk); #1;
    check("irq_set", 32'(irq[0]), 32'h1);
    wr(3, 2, 32'h6);
    check("irq_before_clr", 32'(irq[0]), 32'h1);
    @(posedge clk); #1;
    check("irq_clr", 32'(irq[0]), 32'h0);
    rd_check("ctrl_after_clr", 3, 2, 32'h2);
    // done_clr landing on the completion edge: done must stay set
    wr(3, 0, 32'd15);
    wr(3, 1, 32'd5);
    wr(3, 2, 32'h3);
    repeat (3) @(posedge clk);
    wr(3, 2, 32'h6);
    check("same_edge_idle", 32'(busy[3]), 32'h0);
    rd_check("same_edge_done", 3, 2, 32'h6);

    // Decode misses
    held_access(Base + 32'h40, pat);
    check("miss_high", 32'(pat), 32'h0);
    held_access(Base - 32'h10, pat);
    check("miss_low", 32'(pat), 32'h0);

    // Reset mid-computation
    wr(0, 0, 32'hFF);
    wr(0, 1, 32'h1);
    wr(0, 2, 32'h1);
    repeat (3) @(posedge clk);
    #1 check("mid_busy", 32'(busy[0]), 32'h1);
    do_reset(1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    rd_check("mid_rst_result", 0, 3, 32'h0);
    rd_check("mid_rst_ctrl", 0, 2, 32'h0);

    // Randomized operands against the Euclid reference
    for (int it = 0; it < 10; it++) begin
      ch = int'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      wr(ch, 0, ra);
      wr(ch, 1, rb);
      wr(ch, 2, 32'h1);
      wait_idle(ch, 1000, n);
      check("rand_done", 32'(busy[ch]), 32'h0);
      rd_check("rand_result", ch, 3, ref_gcd(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
